// File: rtl/rv32i_pkg.sv
// Shared RV32I memory-stage definitions: opcodes, funct3 widths, error codes
// and the memory-stage FSM encoding.
package rv32i_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_RESP = 2'b10,
        ST_DONE = 2'b11
    } state_e;

endpackage

// File: rtl/load_store_align.sv
// Combinational lane handling: load/store decode, store byte-lane replication and
// strobes, load byte/half extraction with sign/zero extension, misalignment check.
module load_store_align
    import rv32i_pkg::*;
(
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic        is_load,
    output logic        is_store,
    output logic        misaligned,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic [31:0] load_data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Pick the addressed byte and half out of the returned word.
    always_comb begin
        case (addr_lo)
            2'b00:   byte_s = rdata[7:0];
            2'b01:   byte_s = rdata[15:8];
            2'b10:   byte_s = rdata[23:16];
            2'b11:   byte_s = rdata[31:24];
            default: byte_s = 8'h00;
        endcase
        if (addr_lo[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
    end

    // Decode access width; undefined funct3 leaves the instruction as a pass-through.
    always_comb begin
        is_load    = 1'b0;
        is_store   = 1'b0;
        misaligned = 1'b0;
        wdata      = 32'h0000_0000;
        wstrb      = 4'b0000;
        load_data  = 32'h0000_0000;
        if (opcode == OPC_LOAD) begin
            case (funct3)
                F3_B: begin
                    is_load   = 1'b1;
                    load_data = {{24{byte_s[7]}}, byte_s};
                end
                F3_BU: begin
                    is_load   = 1'b1;
                    load_data = {24'h000000, byte_s};
                end
                F3_H: begin
                    is_load    = 1'b1;
                    misaligned = addr_lo[0];
                    load_data  = {{16{half_s[15]}}, half_s};
                end
                F3_HU: begin
                    is_load    = 1'b1;
                    misaligned = addr_lo[0];
                    load_data  = {16'h0000, half_s};
                end
                F3_W: begin
                    is_load    = 1'b1;
                    misaligned = (addr_lo != 2'b00);
                    load_data  = rdata;
                end
                default: begin
                    is_load = 1'b0;
                end
            endcase
        end else if (opcode == OPC_STORE) begin
            case (funct3)
                F3_B: begin
                    is_store = 1'b1;
                    wdata    = {4{store_data[7:0]}};
                    wstrb    = 4'b0001 << addr_lo;
                end
                F3_H: begin
                    is_store   = 1'b1;
                    misaligned = addr_lo[0];
                    wdata      = {2{store_data[15:0]}};
                    if (addr_lo[1]) begin
                        wstrb = 4'b1100;
                    end else begin
                        wstrb = 4'b0011;
                    end
                end
                F3_W: begin
                    is_store   = 1'b1;
                    misaligned = (addr_lo != 2'b00);
                    wdata      = store_data;
                    wstrb      = 4'b1111;
                end
                default: begin
                    is_store = 1'b0;
                end
            endcase
        end else begin
            is_load = 1'b0;
        end
    end

endmodule

// File: rtl/memory_access.sv
// RV32I memory stage: captures the EX_MEM bundle, runs the data-memory handshake
// with a bus-timeout guard, and registers the MEM_WB results.
module memory_access
    import rv32i_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] EX_MEM_ALU_OUT,
    input  logic [31:0] EX_MEM_B,
    input  logic [31:0] EX_MEM_IR,
    input  logic [31:0] EX_MEM_PC,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    output logic [31:0] MEM_WB_LMD,
    output logic [31:0] MEM_WB_ALU_OUT,
    output logic [31:0] MEM_WB_IR,
    output logic [31:0] MEM_WB_PC,
    output logic [1:0]  mem_err
);

    localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] ir_q, ir_d, alu_q, alu_d, b_q, b_d, pc_q, pc_d;
    logic        we_q, we_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] wb_lmd_q, wb_lmd_d, wb_alu_q, wb_alu_d, wb_ir_q, wb_ir_d, wb_pc_q, wb_pc_d;
    logic [1:0]  err_q, err_d;

    logic [31:0] sel_ir_s, sel_alu_s, sel_b_s, sel_pc_s;
    logic        accept_s, timeout_s;
    logic        is_load_s, is_store_s, misaligned_s;
    logic [31:0] wdata_s, load_data_s;
    logic [3:0]  wstrb_s;

    // In IDLE the aligner looks at the incoming bundle, afterwards at the captured one.
    always_comb begin
        if (state_q == ST_IDLE) begin
            sel_ir_s  = EX_MEM_IR;
            sel_alu_s = EX_MEM_ALU_OUT;
            sel_b_s   = EX_MEM_B;
            sel_pc_s  = EX_MEM_PC;
        end else begin
            sel_ir_s  = ir_q;
            sel_alu_s = alu_q;
            sel_b_s   = b_q;
            sel_pc_s  = pc_q;
        end
        accept_s  = (state_q == ST_IDLE) && in_valid;
        timeout_s = (cnt_q == LAST_WAIT) &&
                    (((state_q == ST_REQ) && !mem_gnt) || ((state_q == ST_RESP) && !mem_rvalid));
    end

    load_store_align u_align (
        .opcode     (sel_ir_s[6:0]),
        .funct3     (sel_ir_s[14:12]),
        .addr_lo    (sel_alu_s[1:0]),
        .store_data (sel_b_s),
        .rdata      (mem_rdata),
        .is_load    (is_load_s),
        .is_store   (is_store_s),
        .misaligned (misaligned_s),
        .wdata      (wdata_s),
        .wstrb      (wstrb_s),
        .load_data  (load_data_s)
    );

    // FSM next state; a handshake in the final wait cycle beats the timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && (is_load_s || is_store_s) && !misaligned_s) begin
                    state_d = ST_REQ;
                end else if (in_valid) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_gnt) begin
                    state_d = we_q ? ST_DONE : ST_RESP;
                end else if (timeout_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_RESP: begin
                if (mem_rvalid || timeout_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Capture, wait counter, error code and write-back result computation.
    always_comb begin
        ir_d     = ir_q;
        alu_d    = alu_q;
        b_d      = b_q;
        pc_d     = pc_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        err_d    = err_q;
        wb_lmd_d = wb_lmd_q;
        wb_alu_d = wb_alu_q;
        wb_ir_d  = wb_ir_q;
        wb_pc_d  = wb_pc_q;
        if (((state_q == ST_REQ) || (state_q == ST_RESP)) && (state_d == state_q)) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = 8'd0;
        end
        if (accept_s) begin
            ir_d  = EX_MEM_IR;
            alu_d = EX_MEM_ALU_OUT;
            b_d   = EX_MEM_B;
            pc_d  = EX_MEM_PC;
            we_d  = is_store_s && !misaligned_s;
            if (misaligned_s) begin
                wdata_d = 32'h0000_0000;
                wstrb_d = 4'b0000;
                err_d   = ERR_MISALIGN;
            end else begin
                wdata_d = wdata_s;
                wstrb_d = wstrb_s;
                err_d   = ERR_NONE;
            end
        end else if (timeout_s) begin
            err_d = ERR_TIMEOUT;
        end else begin
            err_d = err_q;
        end
        if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
            wb_alu_d = sel_alu_s;
            wb_ir_d  = sel_ir_s;
            wb_pc_d  = sel_pc_s;
            if ((state_q == ST_RESP) && mem_rvalid) begin
                wb_lmd_d = load_data_s;
            end else begin
                wb_lmd_d = 32'h0000_0000;
            end
        end else begin
            wb_lmd_d = wb_lmd_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 8'd0;
            ir_q     <= 32'h0000_0000;
            alu_q    <= 32'h0000_0000;
            b_q      <= 32'h0000_0000;
            pc_q     <= 32'h0000_0000;
            we_q     <= 1'b0;
            wdata_q  <= 32'h0000_0000;
            wstrb_q  <= 4'b0000;
            err_q    <= ERR_NONE;
            wb_lmd_q <= 32'h0000_0000;
            wb_alu_q <= 32'h0000_0000;
            wb_ir_q  <= 32'h0000_0000;
            wb_pc_q  <= 32'h0000_0000;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ir_q     <= ir_d;
            alu_q    <= alu_d;
            b_q      <= b_d;
            pc_q     <= pc_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            err_q    <= err_d;
            wb_lmd_q <= wb_lmd_d;
            wb_alu_q <= wb_alu_d;
            wb_ir_q  <= wb_ir_d;
            wb_pc_q  <= wb_pc_d;
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        in_ready       = (state_q == ST_IDLE);
        mem_req        = (state_q == ST_REQ);
        out_valid      = (state_q == ST_DONE);
        mem_we         = we_q;
        mem_addr       = {alu_q[31:2], 2'b00};
        mem_wdata      = wdata_q;
        mem_wstrb      = wstrb_q;
        MEM_WB_LMD     = wb_lmd_q;
        MEM_WB_ALU_OUT = wb_alu_q;
        MEM_WB_IR      = wb_ir_q;
        MEM_WB_PC      = wb_pc_q;
        mem_err        = err_q;
    end

endmodule
